// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, primes and drives the ROM address and holds IF/ID.
// Optional build macro DELAY_SLOT_EN: an accepted redirect still captures the delay-slot word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fault
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] plus4_q, plus4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic        slot_free;
  logic        pc_oob;
  logic        redirect_acc;
  logic        target_misaligned;

  assign pc_plus4          = pc_q + 32'd4;
  assign slot_free         = !valid_q || id_ready;
  // Any address bit above the ROM word range marks the PC as outside the fetch window.
  assign pc_oob            = (pc_q >> (ADDR_WIDTH + 2)) != 32'd0;
  assign redirect_acc      = redirect_valid && valid_q && id_ready;
  assign target_misaligned = redirect_target[1:0] != 2'b00;

  // BOOT presents a different address than RUN so the ROM re-evaluates after reset drops.
  always_comb begin
    rom_addr = pc_q;
    if (state_q == StBoot) begin
      rom_addr = RESET_PC + 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    plus4_d = plus4_q;
    valid_d = valid_q;
    fault_d = fault_q;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end

      StRun: begin
        if (slot_free && pc_oob) begin
          state_d = StFault;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (redirect_acc && target_misaligned) begin
          state_d = StFault;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (redirect_acc) begin
          pc_d = redirect_target;
`ifdef DELAY_SLOT_EN
          inst_d  = rom_data;
          id_pc_d = pc_q;
          plus4_d = pc_plus4;
          valid_d = 1'b1;
`else
          valid_d = 1'b0;
`endif
        end else if (slot_free) begin
          inst_d  = rom_data;
          id_pc_d = pc_q;
          plus4_d = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end

      StFault: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      id_pc_q <= 32'd0;
      plus4_q <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
      plus4_q <= plus4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_inst     = inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = plus4_q;
  assign fault       = fault_q;

  // A redirect is only meaningful alongside the handshake that retires the branch.
  redirect_legal_a: assert property (@(posedge clock) disable iff (reset || (state_q != StRun))
    redirect_valid |-> (valid_q && id_ready));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch PCs are queued and checked on each handshake.
module tb_fetch_unit;

  localparam int unsigned AW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        fault;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] sb_q[$];

  always #5 clock = ~clock;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fault          (fault)
  );

  // Word n holds (n+1) * 0x1111_1111; the ROM wraps on its word index.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = (addr >> 2) & ((32'd1 << AW) - 32'd1);
    return (idx + 32'd1) * 32'h1111_1111;
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // An item counts as delivered when valid and ready are both high going into a rising edge.
  always @(negedge clock) begin : monitor
    logic [31:0] exp_pc;
    if (!reset && id_valid && id_ready) begin
      check("sb_nonempty", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() != 0) begin
        exp_pc = sb_q.pop_front();
        check("sb_id_pc", id_pc, exp_pc);
        check("sb_id_inst", id_inst, rom_word(exp_pc));
        check("sb_id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
      end
    end
  end

  task automatic check_reset_values();
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_rom_addr", rom_addr, 32'h4);
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    id_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    step();
    step();
    check_reset_values();
    sb_q.delete();
    reset = 1'b0;
  endtask

  task automatic drain_check();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Sequential run with id_ready high until target is presented; queues first..target.
  task automatic run_to(input logic [31:0] first, input logic [31:0] target);
    int unsigned budget;
    for (int a = int'(first); a <= int'(target); a += 4) sb_q.push_back(32'(a));
    budget = (target - first) / 4 + 8;
    while (!(id_valid && id_pc == target) && budget != 0) begin
      step();
      budget--;
    end
    check("run_to_pc", id_pc, target);
    check("run_to_valid", {31'd0, id_valid}, 32'd1);
  endtask

  initial begin
    // Reset release, first fetches, then a 3-cycle stall at 0x8.
    apply_reset();
    step();
    check("boot_rom_addr", rom_addr, 32'h0);
    check("boot_id_valid", {31'd0, id_valid}, 32'd0);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_q.push_back(32'h8);
    step();
    check("first_valid", {31'd0, id_valid}, 32'd1);
    check("first_pc", id_pc, 32'h0);
    step();
    check("second_pc", id_pc, 32'h4);
    step();
    check("third_pc", id_pc, 32'h8);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", id_pc, 32'h8);
      check("stall_inst", id_inst, rom_word(32'h8));
      check("stall_valid", {31'd0, id_valid}, 32'd1);
      check("stall_rom_addr", rom_addr, 32'hC);
    end
    id_ready = 1'b1;
    sb_q.push_back(32'hC);
    step();
    check("release_pc", id_pc, 32'hC);
    step();
    drain_check();

    // Aligned redirect to 0x40 while 0x8 is accepted.
    apply_reset();
    run_to(32'h0, 32'h8);
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
`ifdef DELAY_SLOT_EN
    check("dslot_pc", id_pc, 32'hC);
    check("dslot_valid", {31'd0, id_valid}, 32'd1);
    sb_q.push_back(32'hC);
`else
    check("bubble_valid", {31'd0, id_valid}, 32'd0);
`endif
    check("redir_rom_addr", rom_addr, 32'h40);
    sb_q.push_back(32'h40);
    step();
    check("redir_pc", id_pc, 32'h40);
    check("redir_valid", {31'd0, id_valid}, 32'd1);
    step();
    drain_check();

    // Misaligned redirect faults; FAULT ignores ready and redirect until reset.
    apply_reset();
    run_to(32'h0, 32'h8);
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    step();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, id_valid}, 32'd0);
    redirect_target = 32'h80;
    for (int i = 0; i < 6; i++) begin
      id_ready       = (i % 2 == 1);
      redirect_valid = (i % 2 == 1);
      step();
      check("fault_valid", {31'd0, id_valid}, 32'd0);
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_rom_addr", rom_addr, 32'hC);
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    drain_check();
    apply_reset();
    run_to(32'h0, 32'h0);
    step();
    drain_check();

    // Sequential run to the top of the ROM; the next PC is out of range.
    apply_reset();
    run_to(32'h0, 32'h3FC);
    check("top_rom_addr", rom_addr, 32'h400);
    step();
    check("oob_fault", {31'd0, fault}, 32'd1);
    check("oob_valid", {31'd0, id_valid}, 32'd0);
    check("oob_no_capture", id_pc, 32'h3FC);
    drain_check();

    // Reset wins over a simultaneous redirect.
    apply_reset();
    run_to(32'h0, 32'h20);
    reset           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step();
    check_reset_values();
    sb_q.delete();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("rerun_boot_rom_addr", rom_addr, 32'h0);
    sb_q.push_back(32'h0);
    step();
    check("rerun_pc", id_pc, 32'h0);
    check("rerun_valid", {31'd0, id_valid}, 32'd1);
    step();
    drain_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
